router_pkt_tx: RTL
==================

# router_pkt_tx

Packet source for the 1x3 router input port. Accepts a packet command (destination address, payload length) and its payload bytes from an upstream producer, buffers the full payload, then serializes header, payload and even-XOR parity onto the router's `data_in`/`pkt_valid` pins, stalling on router `busy`. Sits directly in front of `router_top` and replaces ad-hoc packet driving with a synthesizable, protocol-exact transmitter.

## Interface

- `IDLE_GAP`, 3, idle cycles driven (pkt_valid=0, data 8'h00) after each parity byte before the next command is accepted; legal 0..15.
- `clock`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge where both are high.
- `cmd_addr`  in  2  destination port 0..2; 3 is illegal.
- `cmd_len`  in  6  payload byte count 1..63; 0 is illegal.
- `pay_valid`  in  1  payload byte present.
- `pay_ready`  out  1  payload byte accepted on an edge where both are high.
- `pay_data`  in  8  payload byte.
- `busy`  in  1  router busy; the current output byte is held while high.
- `pkt_data`  out  8  to router `data_in`.
- `pkt_valid`  out  1  to router `pkt_valid`.
- `tx_done`  out  1  one-cycle pulse, packet fully sent including gap.
- `cmd_err`  out  1  one-cycle pulse, illegal command rejected.

## Operation

- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `cmd_ready`=1. On a command handshake: if `cmd_addr`==3 or `cmd_len`==0, then pulse `cmd_err`, stay IDLE, and consume no payload. Otherwise latch the header {len[5:0], addr[1:0]}, init parity = header, and go to LOAD.
- LOAD: `pay_ready`=1. Each handshake writes `pay_data` into a 64x8 buffer at the write index and XORs it into parity. After the len-th byte, go to HEADER. Transmission never starts before the whole payload is buffered, so the router never sees a bubble.
- HEADER: `pkt_valid`=1, `pkt_data`=header. Advance to PAYLOAD on an edge with `busy`=0.
- PAYLOAD: `pkt_valid`=1, `pkt_data`=buf[rd_idx]. rd_idx increments on each edge with `busy`=0. After byte len-1 is consumed, go to PARITY.
- PARITY: `pkt_valid`=0, `pkt_data`=parity. Advance on an edge with `busy`=0 to GAP, or to IDLE with a `tx_done` pulse if `IDLE_GAP`=0.
- GAP: `pkt_valid`=0, `pkt_data`=8'h00 for `IDLE_GAP` cycles. `tx_done` pulses in the last gap cycle, then IDLE.
- Parity: 8-bit XOR of header and all payload bytes. Lengths are 6-bit unsigned; counters are 6-bit with no wrap (max 63).

## Timing

- All outputs are registered except `cmd_ready`/`pay_ready`, which decode state only and do not depend on `busy`.
- Reset (sync, `resetn`=0 at an edge) puts state in IDLE. Reset values: `pkt_valid`=0, `pkt_data`=8'h00, `tx_done`=0, `cmd_err`=0, `pay_ready`=0, `cmd_ready`=1 from the first edge after reset releases. Buffer contents are not reset.
- Reset mid-packet: the packet is abandoned. `pkt_valid`=0 from the next edge and no parity byte is emitted.
- Command to header latency: the header appears on `pkt_data` in the cycle after the edge accepting the last payload byte.
- Byte hold rule: `pkt_data`/`pkt_valid` change only on an edge where `busy`=0, or on state entry. `busy` high for N cycles holds the current byte N extra cycles.
- `busy` is ignored in IDLE, LOAD and GAP.
- With `busy`=0 throughout, a packet of length L occupies L+2 cycles on the pins, plus `IDLE_GAP`.

## Configuration

- `ROUTER_PKT_TX_BAD_PARITY_EN`: when defined, adds input port `force_bad_parity` (1 bit), sampled at the command handshake. If it is set, the transmitted parity byte is the bitwise inverse of the correct parity. This is used for router `err` testing.
- When the macro is undefined, the port is absent and parity is always correct.

## Test plan

- Reset, `busy`=0, then cmd addr=0 len=3 with payload 11,22,33 -> `pkt_data` 0C,11,22,33,0C with `pkt_valid` 1,1,1,1,0; then 3 cycles of 00; `tx_done` pulses once; `cmd_ready`=1 after.
- Same packet with `busy`=1 for 2 cycles during the header -> 0C held 3 cycles, the rest of the sequence unchanged; `busy`=1 during parity -> parity byte held.
- cmd addr=3 len=5 -> `cmd_err` pulse, `pay_ready` stays 0, `pkt_valid` stays 0; cmd len=0 behaves the same.
- cmd addr=2 len=63 with payload 0..62 -> header FE, 63 payload bytes in order, parity = FE XOR (0^1^…^62), `pkt_valid` falls exactly on parity.
- `resetn`=0 for one edge during the 2nd payload byte -> `pkt_valid`=0 next cycle, no parity byte, `cmd_ready`=1; the next packet is sent correctly.
- With `ROUTER_PKT_TX_BAD_PARITY_EN`, `force_bad_parity`=1 on the first packet -> parity byte F3 instead of 0C; the next packet with the flag at 0 -> correct parity.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Handshake and router-pin bundle for router_pkt_tx: command, payload and packet outputs.
interface router_pkt_tx_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              pay_valid;
  logic              pay_ready;
  logic [DATA_W-1:0] pay_data;
  logic              busy;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_valid;
  logic              tx_done;
  logic              cmd_err;

  // Producer / router side
  modport master (
    output cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
    input  cmd_ready, pay_ready, pkt_data, pkt_valid, tx_done, cmd_err
  );

  // Transmitter side
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
    output cmd_ready, pay_ready, pkt_data, pkt_valid, tx_done, cmd_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a full packet payload, then serializes header, payload and XOR parity to the router.
// Optional feature macro: ROUTER_PKT_TX_BAD_PARITY_EN adds force_bad_parity (inverted parity byte).
module router_pkt_tx #(
  parameter int unsigned IDLE_GAP = 3
) (
  input  logic           clock,
  input  logic           resetn,
`ifdef ROUTER_PKT_TX_BAD_PARITY_EN
  input  logic           force_bad_parity,
`endif
  router_pkt_tx_if.slave bus
);
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned GAP_W  = 4;
  localparam logic [GAP_W-1:0] GAP_LAST = (IDLE_GAP == 0) ? '0 : GAP_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              tx_done_q, tx_done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              mem_we_c;
  logic              inv_par;
  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef ROUTER_PKT_TX_BAD_PARITY_EN
  logic inv_par_q, inv_par_d;
  assign inv_par = inv_par_q;
`else
  assign inv_par = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.pay_ready = (state_q == S_LOAD);
  assign bus.pkt_data  = pkt_data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.cmd_err   = cmd_err_q;

  // Next-state and registered-output decode; outputs follow the state being entered
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    parity_d    = parity_q;
    gap_cnt_d   = gap_cnt_q;
    mem_we_c    = 1'b0;
    cmd_err_d   = 1'b0;
    tx_done_d   = 1'b0;
    pkt_valid_d = 1'b0;
    pkt_data_d  = '0;
`ifdef ROUTER_PKT_TX_BAD_PARITY_EN
    inv_par_d   = inv_par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_addr == ADDR_W'(3) || bus.cmd_len == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            hdr_d    = {bus.cmd_len, bus.cmd_addr};
            parity_d = {bus.cmd_len, bus.cmd_addr};
            len_d    = bus.cmd_len;
            wr_idx_d = '0;
            rd_idx_d = '0;
`ifdef ROUTER_PKT_TX_BAD_PARITY_EN
            inv_par_d = force_bad_parity;
`endif
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.pay_valid) begin
          mem_we_c = 1'b1;
          parity_d = parity_q ^ bus.pay_data;
          if (wr_idx_q == len_q - LEN_W'(1)) state_d = S_HEADER;
          else                               wr_idx_d = wr_idx_q + LEN_W'(1);
        end
      end
      S_HEADER: begin
        if (!bus.busy) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!bus.busy) begin
          if (rd_idx_q == len_q - LEN_W'(1)) state_d = S_PARITY;
          else                               rd_idx_d = rd_idx_q + LEN_W'(1);
        end
      end
      S_PARITY: begin
        if (!bus.busy) begin
          gap_cnt_d = '0;
          if (IDLE_GAP == 0) begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end else begin
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_HEADER: begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = hdr_d;
      end
      S_PAYLOAD: begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = mem_q[rd_idx_d];
      end
      S_PARITY:  pkt_data_d = parity_d ^ {DATA_W{inv_par}};
      S_GAP:     tx_done_d  = (gap_cnt_d == GAP_LAST);
      default:   pkt_data_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      parity_q    <= '0;
      gap_cnt_q   <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      parity_q    <= parity_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      tx_done_q   <= tx_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

`ifdef ROUTER_PKT_TX_BAD_PARITY_EN
  always_ff @(posedge clock) begin
    if (!resetn) inv_par_q <= 1'b0;
    else         inv_par_q <= inv_par_d;
  end
`endif

  // Payload buffer is deliberately not reset
  always_ff @(posedge clock) begin
    if (mem_we_c) mem_q[wr_idx_q] <= bus.pay_data;
  end
endmodule
